armleobus_latency_mem: RTL
==========================

Name: armleobus_latency_mem

Overview:
- Parametrised ArmleoBus slave memory model for cache, PTW and fetch benches.
- Supports configurable depth, address width, wait-state latency and multi-beat bursts.
- Holds a runtime-programmable fault table that returns `ARMLEOBUS_UNKNOWN_ADDRESS on chosen words.
- Generalises the single-cycle scratch memory. Benches use it to exercise miss/refill timing and access-fault paths without external glue logic.

Parameters:
- ADDR_W, 34, byte address width of the address port.
- DEPTH_LOG2, 16, log2 of memory depth in 32-bit words.
- LATENCY, 2, wait cycles before the first beat completes (0..15).
- BEAT_GAP, 0, wait cycles between consecutive burst beats (0..15).
- FAULT_SLOTS, 4, entries in the runtime fault table (1..16).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- transaction  in  1  master request. Held high until the last beat's transaction_done.
- cmd  in  3  `ARMLEOBUS_CMD_READ or `ARMLEOBUS_CMD_WRITE; any other value is invalid.
- address  in  ADDR_W  byte address of the first beat.
- burstcount  in  4  number of beats. 0 is illegal.
- wdata  in  32  write data, sampled in each beat's done cycle.
- wbyte_enable  in  4  per-byte write enable.
- transaction_done  out  1  one-cycle pulse per beat.
- transaction_response  out  3  response code, valid only while transaction_done=1.
- rdata  out  32  read data, valid only while transaction_done=1, else 0.
- fault_set  in  1  add fault_addr to the fault table.
- fault_clr_all  in  1  empty the fault table.
- fault_addr  in  ADDR_W-2  word address to fault.
- fault_count  out  5  number of occupied fault slots.

Behaviour:
- Reset is asynchronous and active-low. Reset state:
  - FSM=IDLE.
  - transaction_done=0, transaction_response=0, rdata=0.
  - fault table empty, fault_count=0.
  - Memory array is not reset; contents survive reset. Reset mid-burst aborts the burst with no further done pulses.
- FSM states are IDLE, WAIT, BEAT.
  - IDLE: transaction=1 at posedge latches cmd, address[ADDR_W-1:2], burstcount. Wait counter loads LATENCY. Next state is WAIT if LATENCY>0, else BEAT.
  - WAIT: counter decrements each cycle; goes to BEAT when it reaches 0.
  - BEAT: transaction_done=1 for exactly one cycle. Beat counter increments and word address increments by 1.
    - If more beats remain: go to WAIT with counter=BEAT_GAP, or stay in BEAT when BEAT_GAP=0 (back-to-back).
    - After the last beat: go to IDLE.
- After the last done, the FSM spends at least one cycle in IDLE. transaction still high in that cycle starts a new transaction.
- First-beat latency: done is high in cycle LATENCY+1 counted from the accept edge.
- Per-beat response, checked in this priority order:
  1. address[1:0]!=0, invalid cmd, or burstcount=0: `ARMLEOBUS_INVALID_OPERATION on a single done. The burst ends immediately and no write occurs.
  2. Word address >= 2^DEPTH_LOG2, or any upper address bits set: `ARMLEOBUS_UNKNOWN_ADDRESS.
  3. Word address matches a valid fault slot: `ARMLEOBUS_UNKNOWN_ADDRESS.
  4. Otherwise `ARMLEOBUS_RESPONSE_SUCCESS.
- Beats with an error response (cases 2 and 3):
  - Writes are suppressed and rdata=0.
  - The burst continues to burstcount beats.
- Write beat: bytes with wbyte_enable[i]=1 are written at the done edge. Read beat: rdata is the array word, combinational in the done cycle.
- Fault table:
  - fault_set allocates the lowest free slot.
  - If the address is already present, or the table is full, the set is ignored and fault_count saturates at FAULT_SLOTS.
  - fault_clr_all takes priority over a simultaneous fault_set.
  - Table changes take effect on the cycle after the edge, and may occur mid-burst.
- Master-side protocol violations are undefined: changing cmd, address or burstcount mid-burst, or dropping transaction early.

Optional Feature:
- Macro: ARMLEOBUS_MEM_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Galois LFSR (seed 16'hACE1, reset to seed) adds 0..3 extra wait cycles before every beat, using LFSR[1:0] sampled when the WAIT counter loads.
  - The LFSR advances every cycle.
  - Stalls apply even when LATENCY=0 or BEAT_GAP=0.
- Undefined: timing is exactly LATENCY and BEAT_GAP; no LFSR logic is present.

Test Plan:
1. LATENCY=2. Write 32'h1 to 0x104, then read 0x104. Required: each done appears in cycle 3 after accept, read rdata=32'h1, response SUCCESS.
2. BEAT_GAP=0. Write burstcount=4 at 0x200 with data 0xA0..0xA3, then read-burst it back. Required: 4 consecutive done pulses, rdata 0xA0,0xA1,0xA2,0xA3.
3. Write 0xFFFFFFFF to 0x300, then write 0x00 with wbyte_enable=4'b0010. Required: readback 0xFFFF00FF.
4. fault_set on word 0xC1, then read-burst 3 beats at 0x300. Required: responses SUCCESS, UNKNOWN_ADDRESS, SUCCESS, with the middle rdata=0. After fault_clr_all, all 3 beats return SUCCESS.
5. Read 0x10002 (misaligned), read 0x40000 (out of range), and cmd=3'b111. Required: INVALID_OPERATION, UNKNOWN_ADDRESS, INVALID_OPERATION respectively, each with exactly one done.
6. Set 5 distinct faults with FAULT_SLOTS=4. Required: fault_count=4. Then assert rst_n low mid-burst. Required: done=0 immediately, fault_count=0, and memory contents intact on a later read.

Source files
------------

// File: rtl/armleobus_latency_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | armleobus_latency_mem                                                    |
// | ArmleoBus slave memory with wait states, bursts and a runtime fault table|
// | Option: ARMLEOBUS_MEM_RANDOM_STALL_EN adds LFSR-driven extra stalls.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef ARMLEOBUS_CMD_READ
`define ARMLEOBUS_CMD_READ (3'd1)
`endif
`ifndef ARMLEOBUS_CMD_WRITE
`define ARMLEOBUS_CMD_WRITE (3'd2)
`endif
`ifndef ARMLEOBUS_RESPONSE_SUCCESS
`define ARMLEOBUS_RESPONSE_SUCCESS (3'd0)
`endif
`ifndef ARMLEOBUS_UNKNOWN_ADDRESS
`define ARMLEOBUS_UNKNOWN_ADDRESS (3'd1)
`endif
`ifndef ARMLEOBUS_INVALID_OPERATION
`define ARMLEOBUS_INVALID_OPERATION (3'd2)
`endif

module armleobus_latency_mem #(
  parameter int ADDR_W      = 34,
  parameter int DEPTH_LOG2  = 16,
  parameter int LATENCY     = 2,
  parameter int BEAT_GAP    = 0,
  parameter int FAULT_SLOTS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              transaction,
  input  logic [2:0]        cmd,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        burstcount,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wbyte_enable,
  output logic              transaction_done,
  output logic [2:0]        transaction_response,
  output logic [31:0]       rdata,
  input  logic              fault_set,
  input  logic              fault_clr_all,
  input  logic [ADDR_W-3:0] fault_addr,
  output logic [4:0]        fault_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2
  } state_t;

  state_t            state;
  logic [4:0]        cnt;
  logic [3:0]        beats_left;
  logic [ADDR_W-3:0] word_addr;
  logic [2:0]        cmd_q;
  logic              invalid_q;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic [4:0] stall;
`ifdef ARMLEOBUS_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end
  assign stall = {3'b000, lfsr[1:0]};
`else
  assign stall = 5'd0;
`endif

  logic [4:0] lat_load;
  logic [4:0] gap_load;
  assign lat_load = 5'(LATENCY) + stall;
  assign gap_load = 5'(BEAT_GAP) + stall;

  // Fault table: lookup for the current beat, duplicate check and lowest-free allocation.
  logic [FAULT_SLOTS-1:0] fvalid;
  logic [ADDR_W-3:0]      faddr [FAULT_SLOTS];
  logic [FAULT_SLOTS-1:0] alloc;
  logic                   fault_hit;
  logic                   set_present;
  logic                   free_found;

  always_comb begin
    fault_hit   = 1'b0;
    set_present = 1'b0;
    free_found  = 1'b0;
    alloc       = '0;
    for (int i = 0; i < FAULT_SLOTS; i++) begin
      if (fvalid[i] && faddr[i] == word_addr)  fault_hit   = 1'b1;
      if (fvalid[i] && faddr[i] == fault_addr) set_present = 1'b1;
      if (!fvalid[i] && !free_found) begin
        free_found = 1'b1;
        alloc[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fvalid      <= '0;
      fault_count <= 5'd0;
      for (int i = 0; i < FAULT_SLOTS; i++) faddr[i] <= '0;
    end else if (fault_clr_all) begin
      fvalid      <= '0;
      fault_count <= 5'd0;
    end else if (fault_set && !set_present && free_found) begin
      fault_count <= fault_count + 5'd1;
      for (int i = 0; i < FAULT_SLOTS; i++) begin
        if (alloc[i]) begin
          fvalid[i] <= 1'b1;
          faddr[i]  <= fault_addr;
        end
      end
    end
  end

  logic       out_of_range;
  logic [2:0] resp;
  logic       beat_ok;
  assign out_of_range = (word_addr >> DEPTH_LOG2) != '0;

  always_comb begin
    resp = `ARMLEOBUS_RESPONSE_SUCCESS;
    if (invalid_q)                      resp = `ARMLEOBUS_INVALID_OPERATION;
    else if (out_of_range || fault_hit) resp = `ARMLEOBUS_UNKNOWN_ADDRESS;
  end

  assign beat_ok              = (state == BEAT) && (resp == `ARMLEOBUS_RESPONSE_SUCCESS);
  assign transaction_done     = (state == BEAT);
  assign transaction_response = transaction_done ? resp : 3'd0;
  assign rdata = (beat_ok && cmd_q == `ARMLEOBUS_CMD_READ) ?
                 mem[word_addr[DEPTH_LOG2-1:0]] : 32'd0;

  always_ff @(posedge clk) begin
    if (beat_ok && cmd_q == `ARMLEOBUS_CMD_WRITE) begin
      for (int i = 0; i < 4; i++) begin
        if (wbyte_enable[i]) mem[word_addr[DEPTH_LOG2-1:0]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // WAIT leaves on cnt==1 so that a load of N gives exactly N wait cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      beats_left <= 4'd0;
      word_addr  <= '0;
      cmd_q      <= 3'd0;
      invalid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (transaction) begin
            cmd_q      <= cmd;
            word_addr  <= address[ADDR_W-1:2];
            beats_left <= burstcount;
            invalid_q  <= (address[1:0] != 2'b00) || (burstcount == 4'd0) ||
                          ((cmd != `ARMLEOBUS_CMD_READ) && (cmd != `ARMLEOBUS_CMD_WRITE));
            cnt        <= lat_load;
            state      <= (lat_load == 5'd0) ? BEAT : WAIT;
          end
        end
        WAIT: begin
          if (cnt <= 5'd1) state <= BEAT;
          else             cnt   <= cnt - 5'd1;
        end
        BEAT: begin
          word_addr  <= word_addr + 1'b1;
          beats_left <= beats_left - 4'd1;
          if (invalid_q || beats_left <= 4'd1) begin
            state <= IDLE;
          end else if (gap_load != 5'd0) begin
            cnt   <= gap_load;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
